// File: rtl/instruction_decode.sv
// ID stage of the 5-stage MIPS pipeline: register file, decode, j/beq/bne resolution, load-use stall.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data into register reads.
module instruction_decode #(
    parameter int          RF_DEPTH = 32,
    parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic [31:0] IR,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    output logic [31:0] PCout,
    output logic        stall,
    output logic [31:0] id_pc,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_ext,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_dst
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] regfile [RF_DEPTH];
    logic        squash;

    logic [5:0]  opcode;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [31:0] sext_imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] next_pcout;

    logic dec_valid;
    logic dec_reg_write;
    logic dec_mem_read;
    logic dec_mem_write;
    logic dec_alu_src;
    logic dec_reg_dst;
    logic reads_rt;

    assign opcode     = IR[31:26];
    assign rs_idx     = IR[25:21];
    assign rt_idx     = IR[20:16];
    assign rd_idx     = IR[15:11];
    assign sext_imm   = {{16{IR[15]}}, IR[15:0]};
    assign branch_tgt = PC + {sext_imm[29:0], 2'b00};
    assign jump_tgt   = {PC[31:28], IR[25:0], 2'b00};

    always_comb begin
        rs_val = (rs_idx == 5'd0) ? 32'd0 : regfile[rs_idx];
        rt_val = (rt_idx == 5'd0) ? 32'd0 : regfile[rt_idx];
`ifdef WB_BYPASS_EN
        if (wb_en && wb_addr != 5'd0 && wb_addr == rs_idx) rs_val = wb_data;
        if (wb_en && wb_addr != 5'd0 && wb_addr == rt_idx) rt_val = wb_data;
`endif
    end

    always_comb begin
        dec_valid     = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_reg_dst   = 1'b0;
        reads_rt      = 1'b0;
        if (IR != NOP_IR) begin
            case (opcode)
                OP_RTYPE: begin
                    dec_valid     = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_reg_dst   = 1'b1;
                    reads_rt      = 1'b1;
                end
                OP_ADDI: begin
                    dec_valid     = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_alu_src   = 1'b1;
                end
                OP_LW: begin
                    dec_valid     = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_mem_read  = 1'b1;
                    dec_alu_src   = 1'b1;
                end
                OP_SW: begin
                    dec_valid     = 1'b1;
                    dec_mem_write = 1'b1;
                    dec_alu_src   = 1'b1;
                    reads_rt      = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    dec_valid = 1'b1;
                    reads_rt  = 1'b1;
                end
                OP_J: dec_valid = 1'b1;
                default: dec_valid = 1'b0;
            endcase
        end
    end

    // Squash wins over stall: a wrong-path instruction never holds fetch.
    assign stall = !rst && !squash && ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == rs_idx) || (reads_rt && ex_rt == rt_idx));

    always_comb begin
        next_pcout = 32'd0;
        if (!squash && !stall && dec_valid) begin
            case (opcode)
                OP_BEQ:  if (rs_val == rt_val) next_pcout = branch_tgt;
                OP_BNE:  if (rs_val != rt_val) next_pcout = branch_tgt;
                OP_J:    next_pcout = jump_tgt;
                default: next_pcout = 32'd0;
            endcase
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) regfile[i] <= 32'd0;
            squash    <= 1'b0;
            PCout     <= 32'd0;
            id_pc     <= 32'd0;
            rs_data   <= 32'd0;
            rt_data   <= 32'd0;
            imm_ext   <= 32'd0;
            rs        <= 5'd0;
            rt        <= 5'd0;
            rd        <= 5'd0;
            funct     <= 6'd0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            alu_src   <= 1'b0;
            reg_dst   <= 1'b0;
        end else begin
            if (wb_en && wb_addr != 5'd0) regfile[wb_addr] <= wb_data;
            PCout  <= next_pcout;
            squash <= (next_pcout != 32'd0);
            if (squash || stall || !dec_valid) begin
                id_pc     <= 32'd0;
                rs_data   <= 32'd0;
                rt_data   <= 32'd0;
                imm_ext   <= 32'd0;
                rs        <= 5'd0;
                rt        <= 5'd0;
                rd        <= 5'd0;
                funct     <= 6'd0;
                reg_write <= 1'b0;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                alu_src   <= 1'b0;
                reg_dst   <= 1'b0;
            end else begin
                id_pc     <= PC;
                rs_data   <= rs_val;
                rt_data   <= rt_val;
                imm_ext   <= sext_imm;
                rs        <= rs_idx;
                rt        <= rt_idx;
                rd        <= rd_idx;
                funct     <= IR[5:0];
                reg_write <= dec_reg_write;
                mem_read  <= dec_mem_read;
                mem_write <= dec_mem_write;
                alu_src   <= dec_alu_src;
                reg_dst   <= dec_reg_dst;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed plan steps plus randomized traffic vs. a reference model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PC = 32'd0;
    logic [31:0] IR = 32'd0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = 5'd0;
    logic [31:0] PCout;
    logic        stall;
    logic [31:0] id_pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_pcout = 32'd0;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst(rst), .PC(PC), .IR(IR),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .PCout(PCout), .stall(stall), .id_pc(id_pc),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .reg_dst(reg_dst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (we && wa != 5'd0 && wa == idx) return wd;
`endif
        return m_rf[idx];
    endfunction

    // One clock of stimulus; every output is compared against the model.
    task automatic cycle(input logic r, input logic [31:0] pc, input logic [31:0] ir,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mr, input logic [4:0] ert);
        logic [5:0]  op;
        logic [4:0]  rsi, rti;
        logic [31:0] a, b, sx, e_pcout;
        logic        wrong_path, rrt, e_stall, known, bubble;
        logic [31:0] e_idpc, e_rsd, e_rtd, e_imm;
        logic [4:0]  e_rs, e_rt, e_rd;
        logic [5:0]  e_fn;
        logic        e_rw, e_mr, e_mw, e_as, e_rdst;

        rst = r; PC = pc; IR = ir; wb_en = we; wb_addr = wa; wb_data = wd;
        ex_mem_read = mr; ex_rt = ert;

        op  = ir[31:26];
        rsi = ir[25:21];
        rti = ir[20:16];
        a   = mread(rsi, we, wa, wd);
        b   = mread(rti, we, wa, wd);
        sx  = {{16{ir[15]}}, ir[15:0]};
        wrong_path = (m_pcout != 32'd0);
        rrt     = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        e_stall = !r && !wrong_path && mr && ert != 5'd0 && (ert == rsi || (rrt && ert == rti));
        known   = (ir != 32'd0) && (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02});

        e_pcout = 32'd0;
        if (!r && known && !wrong_path && !e_stall) begin
            if (op == 6'h04 && a == b) e_pcout = pc + sx * 4;
            if (op == 6'h05 && a != b) e_pcout = pc + sx * 4;
            if (op == 6'h02) e_pcout = {pc[31:28], ir[25:0], 2'b00};
        end

        bubble = r || wrong_path || e_stall || !known;
        e_idpc = bubble ? 32'd0 : pc;
        e_rsd  = bubble ? 32'd0 : a;
        e_rtd  = bubble ? 32'd0 : b;
        e_imm  = bubble ? 32'd0 : sx;
        e_rs   = bubble ? 5'd0 : rsi;
        e_rt   = bubble ? 5'd0 : rti;
        e_rd   = bubble ? 5'd0 : ir[15:11];
        e_fn   = bubble ? 6'd0 : ir[5:0];
        e_rw   = !bubble && (op == 6'h00 || op == 6'h08 || op == 6'h23);
        e_mr   = !bubble && (op == 6'h23);
        e_mw   = !bubble && (op == 6'h2B);
        e_as   = !bubble && (op == 6'h08 || op == 6'h23 || op == 6'h2B);
        e_rdst = !bubble && (op == 6'h00);

        @(negedge clk);
        chk("stall", stall, e_stall);
        @(posedge clk);
        #1;
        chk("PCout", PCout, e_pcout);
        chk("id_pc", id_pc, e_idpc);
        chk("rs_data", rs_data, e_rsd);
        chk("rt_data", rt_data, e_rtd);
        chk("imm_ext", imm_ext, e_imm);
        chk("rs", rs, e_rs);
        chk("rt", rt, e_rt);
        chk("rd", rd, e_rd);
        chk("funct", funct, e_fn);
        chk("reg_write", reg_write, e_rw);
        chk("mem_read", mem_read, e_mr);
        chk("mem_write", mem_write, e_mw);
        chk("alu_src", alu_src, e_as);
        chk("reg_dst", reg_dst, e_rdst);

        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_pcout = 32'd0;
        end else begin
            if (we && wa != 5'd0) m_rf[wa] = wd;
            m_pcout = e_pcout;
        end
    endtask

    initial begin
        logic [5:0]  ops [8];
        logic [31:0] ir;
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
        for (int i = 0; i < 32; i++) m_rf[i] = 32'hFFFF_FFFF;
        #1;

        // Reset with a lw in IR and a would-be hazard on its rs.
        cycle(1'b1, 32'h4, 32'h8C220004, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1);
        cycle(1'b1, 32'h4, 32'h8C220004, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1);
        chk("reset_pcout", PCout, 32'd0);

        // Register read-back after reset.
        for (int i = 1; i < 32; i++) begin
            ir = {6'h00, i[4:0], i[4:0], 5'd3, 5'd0, 6'h20};
            cycle(1'b0, 32'h100, ir, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            chk("readback_rs", rs_data, 32'd0);
        end

        // Writeback then R-type add r3,r1,r2.
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 32'd5, 1'b0, 5'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0);
        cycle(1'b0, 32'h8, 32'h00221820, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("add_rs_data", rs_data, 32'd5);
        chk("add_rt_data", rt_data, 32'd7);
        chk("add_rd", rd, 5'd3);
        chk("add_reg_dst", reg_dst, 1'b1);

        // Taken beq, then a wrong-path add is squashed.
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 32'd9, 1'b0, 5'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'd2, 32'd9, 1'b0, 5'd0);
        cycle(1'b0, 32'h10, 32'h10220003, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("beq_target", PCout, 32'h1C);
        cycle(1'b0, 32'h14, 32'h00221820, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1);
        chk("squash_reg_write", reg_write, 1'b0);
        chk("squash_pcout", PCout, 32'd0);

        // Jump.
        cycle(1'b0, 32'h00400008, 32'h08000040, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("j_target", PCout, 32'h100);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("j_pcout_clear", PCout, 32'd0);

        // Load-use on rs=r4.
        cycle(1'b0, 32'h20, 32'h00802820, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        chk("lu_bubble", reg_write, 1'b0);
        cycle(1'b0, 32'h20, 32'h00802820, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4);
        chk("lu_release_rs", rs, 5'd4);

        // Same-cycle writeback to r6 and an attempted write to r0.
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'd6, 32'h11111111, 1'b0, 5'd0);
        cycle(1'b0, 32'h30, 32'h00C03820, 1'b1, 5'd6, 32'hDEADBEEF, 1'b0, 5'd0);
`ifdef WB_BYPASS_EN
        chk("bypass_rs", rs_data, 32'hDEADBEEF);
`else
        chk("bypass_rs", rs_data, 32'h11111111);
`endif
        cycle(1'b0, 32'h34, 32'h00003820, 1'b1, 5'd0, 32'hFFFF0000, 1'b0, 5'd0);
        chk("r0_write_rs", rs_data, 32'd0);

        // Randomized traffic with small register indices to provoke hazards and equal compares.
        for (int n = 0; n < 500; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 7)];
            ir = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom())};
            if ($urandom_range(0, 9) == 0) ir = 32'd0;
            cycle(($urandom_range(0, 99) == 0), $urandom() & 32'hFFFF_FFFC, ir,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
ID stage of the 5-stage MIPS pipeline. It consumes PC/IR from instruction fetch and holds the 32x32 register file with its writeback port. It resolves j/beq/bne in ID and returns the redirect target to fetch on PCout, and registers the ID/EX pipeline bundle. It also detects load-use hazards and raises stall toward fetch.

Parameters:
RF_DEPTH, 32, number of architectural registers; r0 is hardwired to 0.
NOP_IR, 32'h00000000, encoding treated as a bubble; also injected on squash or stall.

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst  in  1  reset, synchronous and active-high; sampled on posedge clk
PC  in  32  fetch PC paired with IR; equals address of IR + 4
IR  in  32  instruction from fetch; 0 = bubble
wb_en  in  1  writeback enable from WB stage
wb_addr  in  5  writeback register index
wb_data  in  32  writeback data
ex_mem_read  in  1  instruction currently in EX is lw
ex_rt  in  5  destination of the instruction in EX
PCout  out  32  redirect target to fetch; 0 = no redirect
stall  out  1  combinational load-use stall; fetch holds PC/IR while high
id_pc  out  32  registered PC of decoded instruction
rs_data  out  32  registered rs operand
rt_data  out  32  registered rt operand
imm_ext  out  32  registered sign-extended imm16
rs, rt, rd  out  5 each  registered register indices
funct  out  6  registered IR[5:0]
reg_write, mem_read, mem_write, alu_src, reg_dst  out  1 each  registered control bits

Behaviour:
- Clock and reset: single clock clk; synchronous active-high rst.
- Reset state: all outputs 0. PCout=0, stall=0, all ID/EX fields and controls 0. Register file cleared to 0. The squash flag is cleared.
- Register file write: on posedge when wb_en=1 and wb_addr!=0, write regfile[wb_addr]<=wb_data. Writes to r0 are ignored. Reads of index 0 always return 0.
- Decode (opcode = IR[31:26]):
  - R-type 0x00: reg_write=1, reg_dst=1.
  - addi 0x08: reg_write=1, alu_src=1.
  - lw 0x23: reg_write=1, mem_read=1, alu_src=1.
  - sw 0x2B: mem_write=1, alu_src=1.
  - beq 0x04 and bne 0x05: no control bits set.
  - j 0x02: no control bits set.
  - Any other opcode: all controls 0; decoded as a bubble.
- imm_ext = {{16{IR[15]}}, IR[15:0]}.
- Branch/jump resolution, computed combinationally from the current IR and registered into PCout:
  - beq taken if rs_val==rt_val; bne taken if rs_val!=rt_val.
  - Branch target = PC + (imm_ext<<2), 32-bit wrap-around.
  - j target = {PC[31:28], IR[25:0], 2'b00}.
  - A taken branch or jump sets PCout<=target for exactly one cycle. Otherwise PCout<=0.
  - A target of 0 cannot be redirected (0 means "no redirect"); this is a software restriction.
- Squash:
  - The instruction presented in the cycle PCout!=0 is wrong-path. Its ID/EX bundle is loaded as a bubble (all controls 0) and it cannot redirect.
  - One squash cycle only; fetch zeroes IR thereafter.
- Load-use hazard:
  - stall=1 when ex_mem_read=1, ex_rt!=0, and ex_rt matches rs, or matches rt for an opcode that reads rt (R-type, sw, beq, bne).
  - While stall=1: ID/EX is loaded as a bubble, PCout<=0 and the branch is not evaluated. The same PC/IR is re-presented the next cycle.
  - stall is forced to 0 during rst and while squashing.
- Simultaneous events:
  - rst dominates everything.
  - Squash dominates stall.
  - Writeback to a register in the same cycle it is read: see WB_BYPASS_EN.
- ID/EX latency: 1 cycle. Fields are valid on the edge after IR is presented.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: rs_val/rt_val return wb_data when wb_en=1, wb_addr!=0 and wb_addr matches the read index. This applies to both the branch compare and the registered operands.
- Undefined: reads return the pre-write register file contents. A reader must be at least one cycle after the writeback; software spaces dependent instructions accordingly.

Test Plan:
- Reset: assert rst for 2 cycles with IR=32'h8C220004 -> all outputs 0 and regfile[1..31]=0 on read-back; stall=0.
- Writeback + R-type: wb r1=5, r2=7; then IR=add r3,r1,r2 (32'h00221820) -> next edge rs_data=5, rt_data=7, rd=3, reg_write=1, reg_dst=1, PCout=0.
- Branch taken with squash: r1=r2=9; PC=32'h00000010, IR=beq r1,r2,+3 (32'h10220003) -> PCout=32'h0000001C for one cycle; the following IR is bubbled (all controls 0).
- Jump: PC=32'h00400008, IR=j 0x0000040 (32'h08000040) -> PCout=32'h00000100 for one cycle, then 0.
- Load-use: ex_mem_read=1, ex_rt=4, IR=add r5,r4,r0 -> stall=1 the same cycle; ID/EX bubble. Drop ex_mem_read -> stall=0 and add decodes with rs=4.
- Bypass: same cycle wb_en=1, wb_addr=6, wb_data=32'hDEADBEEF and IR reads r6 -> rs_data=32'hDEADBEEF with WB_BYPASS_EN defined, old value without it; r0 write attempt leaves rs_data=0.
